stream_fifo: RTL and testbench
==============================

Name: stream_fifo

Overview:
- Synchronous first-word-fall-through (FWFT) FIFO with valid/ready handshakes on both sides.
- Sits directly upstream of the example datapath stage and buffers bursts from the producer so the consumer's always_ff/always_comb logic sees a clean valid/ready stream.
- Provides occupancy count, almost-full/almost-empty watermarks and a synchronous flush.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 8, number of entries; power of two, >=2.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  in  1  single clock, all logic on posedge clk.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- flush  in  1  synchronous clear of contents; takes priority over push and pop.
- in_valid  in  1  producer has a word.
- in_ready  out  1  FIFO accepts a word this cycle.
- in_data  in  WIDTH  write data.
- out_valid  out  1  head word available.
- out_ready  in  1  consumer takes head word.
- out_data  out  WIDTH  head word; valid only while out_valid=1.
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.

Behaviour:
- Reset (async assert, sync release): wr_ptr=rd_ptr=0, count=0, in_ready=1, out_valid=0, almost_full=0, almost_empty=1. Storage contents are don't-care. out_data is don't-care while out_valid=0.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It is registered-state-derived only, with no combinational path from out_ready.
- out_valid = (count != 0).
- out_data = mem[rd_ptr]. This is a combinational read (FWFT).
- Latency: a word pushed in cycle N is visible at out_data with out_valid=1 in cycle N+1. There is no bypass while empty.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Full/empty are decided from count, not from pointer compare.
- Count update per cycle:
  - push only: +1.
  - pop only: -1.
  - push & pop: unchanged. Write and read both occur, and the pointers both advance.
- Full with out_ready=1: in_ready stays 0 that cycle; the pop frees a slot and in_ready=1 next cycle.
- Empty with in_valid=1: push accepted; out_valid=0 this cycle, 1 next.
- in_valid=1 while in_ready=0: no write, no error. The producer must hold its data.
- Producer/consumer rule: once in_valid/out_valid is asserted, it must not drop until handshake. The FIFO guarantees this for out_valid, since count only decreases on pop.
- flush=1 has priority: next cycle count=0, both pointers 0, out_valid=0, in_ready=1. A push or pop in the same cycle is discarded.
- Watermarks: almost_full and almost_empty are computed combinationally from registered count. There is no extra latency beyond count.
- Width rules: count = WIDTH-independent $clog2(DEPTH+1) bits. Comparisons against AF_LEVEL/AE_LEVEL are unsigned, at count width.
- Assertions (sim only):
  - count never exceeds DEPTH.
  - no pop while count=0.
  - DEPTH is a power of two.
  - AE_LEVEL < AF_LEVEL.

Decomposition:
- Package stream_fifo_pkg holds:
  - function clog2_cnt(depth) returning the count width;
  - localparam defaults for WIDTH/DEPTH;
  - typedef enum for a sim-only status view {EMPTY, PARTIAL, FULL}.
- Sub-module stream_fifo_mem: DEPTH x WIDTH register array, one write port (we, waddr, wdata) on always_ff @(posedge clk), and an async read port (raddr -> rdata) in always_comb. It has no reset.
- Pointers, count and handshake logic stay in stream_fifo.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release -> count=0, in_ready=1, out_valid=0, almost_empty=1, almost_full=0.
- Fill/drain, DEPTH=8: push 0x01..0x08 with out_ready=0 -> count=8, in_ready=0, almost_full=1 from count 6. Then out_ready=1 -> out_data reads 0x01..0x08 in order, count back to 0.
- Simultaneous push/pop at full: count=8, in_valid=1, out_ready=1 -> pop 0x01, no push that cycle, count=7. Next cycle push accepted, count stays 7 with continuous traffic.
- Pointer wrap: stream 20 words 0x10..0x23 with out_ready toggling every cycle -> output sequence identical and gap-free in order, count never >8, pointers wrap at least twice.
- Flush mid-operation: count=5, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0. The next pushed word 0xAA appears as first output.
- Async reset mid-burst: assert rst between clock edges with count=3 -> outputs go to reset values immediately, without waiting for clk. After release, first push 0x55 appears at out_data one cycle later.

Source files
------------

// File: rtl/stream_fifo_pkg.sv
// Shared definitions for the stream_fifo block: default sizes, the count-width
// helper and a status view used by the checking logic.
package stream_fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    // Occupancy runs 0..depth inclusive, so one more code than entries is needed.
    function automatic int clog2_cnt(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Coarse occupancy view, only consumed by simulation checks.
    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } fifo_status_e;

endpackage

// File: rtl/stream_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port and one
// asynchronous read port feeding the first-word-fall-through output.
module stream_fifo_mem
    import stream_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry on an accepted push.
    // NOTE: the storage array has no reset; its contents are don't-care until
    // written and the count guards every read, so a reset here would only cost flops.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Head word is presented combinationally so it is visible the cycle after the push.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO with valid/ready on both sides, occupancy
// count, almost-full/almost-empty watermarks and a synchronous flush.
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [clog2_cnt(DEPTH)-1:0]   count,
    output logic                          almost_full,
    output logic                          almost_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = clog2_cnt(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    fifo_status_e  status;

    // Handshake and watermark flags come from registered count only, so
    // in_ready has no combinational path from out_ready.
    always_comb begin
        in_ready     = (count != CW'(DEPTH));
        out_valid    = (count != '0);
        push         = in_valid & in_ready;
        pop          = out_valid & out_ready;
        almost_full  = (count >= CW'(AF_LEVEL));
        almost_empty = (count <= CW'(AE_LEVEL));
    end

    stream_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push & ~flush),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (out_data)
    );

    // Pointer and occupancy state; flush wins over any push or pop in the same cycle.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Coarse status view for the checks below.
    // NOTE: the default is assigned first so no path through the block can
    // leave status unassigned and infer a latch.
    always_comb begin
        status = PARTIAL;
        if (count == '0) begin
            status = EMPTY;
        end else if (count == CW'(DEPTH)) begin
            status = FULL;
        end
    end

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("stream_fifo: DEPTH must be a power of two and at least 2");
    end

    if (AE_LEVEL >= AF_LEVEL) begin : g_bad_levels
        $error("stream_fifo: AE_LEVEL must be below AF_LEVEL");
    end

    a_count_bound : assert property (@(posedge clk) disable iff (rst)
        count <= CW'(DEPTH));

    a_no_pop_empty : assert property (@(posedge clk) disable iff (rst)
        !(pop && (count == '0)));

    a_full_blocks : assert property (@(posedge clk) disable iff (rst)
        (status == FULL) == !in_ready);

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo with the default 8-entry, 8-bit configuration.
module tb_stream_fifo;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] count;
    logic       almost_full;
    logic       almost_empty;

    int checks   = 0;
    int failures = 0;

    stream_fifo #(
        .WIDTH    (8),
        .DEPTH    (8),
        .AF_LEVEL (6),
        .AE_LEVEL (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] drain_exp [7];
        int sent;
        int recvd;
        int cyc;

        drain_exp = '{8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A, 8'h0B};

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;

        // Reset then idle
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_count", int'(count), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_almost_empty", int'(almost_empty), 1);
        check("rst_almost_full", int'(almost_full), 0);

        // Fill 0x01..0x08 with the consumer stalled
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            check("fill_in_ready", int'(in_ready), 1);
            if (i == 1) check("empty_push_no_bypass", int'(out_valid), 0);
            tick();
            check("fill_count", int'(count), i);
            check("fill_out_valid", int'(out_valid), 1);
            check("fill_almost_full", int'(almost_full), int'(i >= 6));
            check("fill_almost_empty", int'(almost_empty), int'(i <= 2));
        end
        check("full_in_ready", int'(in_ready), 0);
        check("full_head", int'(out_data), 8'h01);

        // Push attempt while full is ignored
        in_data = 8'h99;
        tick();
        check("full_hold_count", int'(count), 8);

        // Push and pop requested at full: only the pop happens
        in_data   = 8'h09;
        out_ready = 1'b1;
        tick();
        check("full_pop_count", int'(count), 7);
        check("full_pop_in_ready", int'(in_ready), 1);

        // Continuous traffic keeps the count steady
        in_data = 8'h0A;
        check("stream_head_a", int'(out_data), 8'h02);
        tick();
        check("stream_count_a", int'(count), 7);
        in_data = 8'h0B;
        check("stream_head_b", int'(out_data), 8'h03);
        tick();
        check("stream_count_b", int'(count), 7);

        // Drain the remainder in order
        in_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            check("drain_valid", int'(out_valid), 1);
            check("drain_data", int'(out_data), int'(drain_exp[k]));
            tick();
        end
        check("drain_count", int'(count), 0);
        check("drain_out_valid", int'(out_valid), 0);
        out_ready = 1'b0;

        // Stream 0x10..0x23 with out_ready toggling every cycle
        sent  = 0;
        recvd = 0;
        cyc   = 0;
        while ((recvd < 20) && (cyc < 200)) begin
            in_valid  = (sent < 20);
            in_data   = 8'h10 + 8'(sent);
            out_ready = cyc[0];
            if (out_valid && out_ready) begin
                check("wrap_data", int'(out_data), 16 + recvd);
                recvd++;
            end
            if (in_valid && in_ready) sent++;
            tick();
            check("wrap_count_bound", int'(count <= 4'd8), 1);
            cyc++;
        end
        check("wrap_received", recvd, 20);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("wrap_final_count", int'(count), 0);

        // Flush with count=5 and a same-cycle push and pop
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h30 + 8'(i);
            tick();
        end
        check("pre_flush_count", int'(count), 5);
        flush     = 1'b1;
        in_data   = 8'h77;
        out_ready = 1'b1;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("flush_count", int'(count), 0);
        check("flush_out_valid", int'(out_valid), 0);
        check("flush_in_ready", int'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        tick();
        in_valid = 1'b0;
        check("post_flush_valid", int'(out_valid), 1);
        check("post_flush_data", int'(out_data), 8'hAA);
        check("post_flush_count", int'(count), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_flush_drain", int'(count), 0);

        // Asynchronous reset between edges with count=3
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h40 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        check("pre_rst_count", int'(count), 3);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_count", int'(count), 0);
        check("async_rst_out_valid", int'(out_valid), 0);
        check("async_rst_in_ready", int'(in_ready), 1);
        check("async_rst_almost_empty", int'(almost_empty), 1);
        check("async_rst_almost_full", int'(almost_full), 0);
        tick();
        rst = 1'b0;
        tick();
        in_valid = 1'b1;
        in_data  = 8'h55;
        check("post_rst_no_bypass", int'(out_valid), 0);
        tick();
        in_valid = 1'b0;
        check("post_rst_valid", int'(out_valid), 1);
        check("post_rst_data", int'(out_data), 8'h55);
        check("post_rst_count", int'(count), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
